// File: rtl/sam_spi_reg_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sam_spi_reg_responder
//
// SPI (mode 0) responder that lets the SAM3U drive the FPGA register bus over
// SAM_SPCK/SAM_MOSI/SAM_CS/SAM_MISO. Frames are: address byte, command byte
// (bit7 = read, bits[6:0] = length, 0 meaning 128), then data bytes. All SPI
// pins are oversampled in the clk_usb domain (clk_usb >= 16x SCK).
//
// Ports:
//   clk_usb, reset_n     : system clock, asynchronous active-low reset
//   enable               : 0 = ignore SPI pins, MISO output enable held low
//   spi_sck/mosi/cs_n    : asynchronous SPI inputs from the SAM3U
//   spi_miso, spi_miso_oe: serial read data (MSB first) and its output enable
//   reg_address/bytecnt/datao, reg_read/write/addrvalid : register-bus master
//   reg_datai            : register-bus read data, sampled after reg_read
//   busy                 : a frame is in progress
//   frame_error          : one-cycle pulse on an aborted or overrun frame
// -----------------------------------------------------------------------------
module sam_spi_reg_responder #(
  parameter int pBYTECNT_SIZE = 7
) (
  input  logic                     clk_usb,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     spi_sck,
  input  logic                     spi_mosi,
  input  logic                     spi_cs_n,
  output logic                     spi_miso,
  output logic                     spi_miso_oe,
  output logic [7:0]               reg_address,
  output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  output logic [7:0]               reg_datao,
  input  logic [7:0]               reg_datai,
  output logic                     reg_read,
  output logic                     reg_write,
  output logic                     reg_addrvalid,
  output logic                     busy,
  output logic                     frame_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CMD,
    S_WDATA,
    S_RDATA,
    S_OVER
  } state_t;

  localparam logic [pBYTECNT_SIZE-1:0] BC_ONE = 1;

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic       r_sck_meta, r_sck_sync, r_sck_prev;
  logic       r_mosi_meta, r_mosi_sync;
  logic       r_cs_n_meta, r_cs_n_sync, r_cs_n_prev;
  logic [1:0] r_warm;

  // NOTE: non-blocking assignments make each flop take the previous stage's
  // old value, which is what builds a real 2-stage synchroniser chain.
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      r_sck_meta  <= 1'b0;
      r_sck_sync  <= 1'b0;
      r_sck_prev  <= 1'b0;
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
      // CS resets to its deasserted level so MISO stays disabled until the
      // real pin value has propagated through the chain.
      r_cs_n_meta <= 1'b1;
      r_cs_n_sync <= 1'b1;
      r_cs_n_prev <= 1'b1;
      r_warm      <= 2'd0;
    end else begin
      r_sck_meta  <= spi_sck;
      r_sck_sync  <= r_sck_meta;
      r_sck_prev  <= r_sck_sync;
      r_mosi_meta <= spi_mosi;
      r_mosi_sync <= r_mosi_meta;
      r_cs_n_meta <= spi_cs_n;
      r_cs_n_sync <= r_cs_n_meta;
      r_cs_n_prev <= r_cs_n_sync;
      if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
    end
  end

  // CS edges are masked until the chain holds only post-reset pin samples, so
  // a frame interrupted by reset (CS still low) is dropped, not re-entered.
  logic w_edges_ok;
  logic w_sck_rise, w_sck_fall;
  logic w_cs_fall, w_cs_rise;

  assign w_edges_ok = (r_warm == 2'd3);
  assign w_sck_rise = r_sck_sync & ~r_sck_prev;
  assign w_sck_fall = ~r_sck_sync & r_sck_prev;
  assign w_cs_fall  = w_edges_ok & ~r_cs_n_sync & r_cs_n_prev;
  assign w_cs_rise  = w_edges_ok & r_cs_n_sync & ~r_cs_n_prev;

  // ---------------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------------
  state_t                   r_state;
  logic [2:0]               r_bit_cnt;
  logic [7:0]               r_shift_in;
  logic [7:0]               r_shift_out;
  logic [7:0]               r_hold;
  logic [7:0]               r_len;
  logic                     r_overrun;
  logic                     r_capture;
  logic                     r_inc_pend;
  logic                     r_miso, r_miso_oe;
  logic [7:0]               r_address;
  logic [pBYTECNT_SIZE-1:0] r_bytecnt;
  logic [7:0]               r_datao;
  logic                     r_read, r_write, r_addrvalid, r_frame_error;

  logic [7:0] w_byte_in;
  logic       w_byte_done;

  assign w_byte_in   = {r_shift_in[6:0], r_mosi_sync};
  assign w_byte_done = w_sck_rise & (r_bit_cnt == 3'd7);

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_bit_cnt     <= 3'd0;
      r_shift_in    <= 8'd0;
      r_shift_out   <= 8'd0;
      r_hold        <= 8'd0;
      r_len         <= 8'd0;
      r_overrun     <= 1'b0;
      r_capture     <= 1'b0;
      r_inc_pend    <= 1'b0;
      r_miso        <= 1'b0;
      r_miso_oe     <= 1'b0;
      r_address     <= 8'd0;
      r_bytecnt     <= '0;
      r_datao       <= 8'd0;
      r_read        <= 1'b0;
      r_write       <= 1'b0;
      r_addrvalid   <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every cycle; the branches below only
      // ever raise them, which keeps them strictly one cycle wide.
      r_read        <= 1'b0;
      r_write       <= 1'b0;
      r_frame_error <= 1'b0;
      r_capture     <= 1'b0;
      r_inc_pend    <= 1'b0;
      r_miso_oe     <= enable & ~r_cs_n_sync;

      // Bookkeeping that follows a strobe by one cycle: the byte index moves
      // on only after the bus has seen the strobe, and read data is captured
      // while reg_bytecnt still points at the byte that was read.
      if (r_inc_pend) r_bytecnt <= r_bytecnt + BC_ONE;
      if (r_capture)  r_hold    <= reg_datai;

      if (!enable) begin
        r_state     <= S_IDLE;
        r_bit_cnt   <= 3'd0;
        r_addrvalid <= 1'b0;
        r_miso      <= 1'b0;
      end else if (w_cs_rise) begin
        // Every state between IDLE and OVER is an unfinished frame.
        if (r_state != S_IDLE && r_state != S_OVER) r_frame_error <= 1'b1;
        r_state     <= S_IDLE;
        r_bit_cnt   <= 3'd0;
        r_addrvalid <= 1'b0;
        r_miso      <= 1'b0;
      end else begin
        if (w_sck_rise && r_state != S_IDLE && r_state != S_OVER) begin
          r_shift_in <= w_byte_in;
          r_bit_cnt  <= r_bit_cnt + 3'd1;
        end

        case (r_state)
          S_IDLE: begin
            if (w_cs_fall) begin
              r_state   <= S_ADDR;
              r_bit_cnt <= 3'd0;
              r_overrun <= 1'b0;
              r_miso    <= 1'b0;
            end
          end

          S_ADDR: begin
            if (w_byte_done) begin
              r_address   <= w_byte_in;
              r_addrvalid <= 1'b1;
              r_state     <= S_CMD;
            end
          end

          S_CMD: begin
            if (w_byte_done) begin
              r_len     <= (w_byte_in[6:0] == 7'd0) ? 8'd128 : {1'b0, w_byte_in[6:0]};
              r_bytecnt <= '0;
              if (w_byte_in[7]) begin
                // First read is fetched now so its data is ready for the
                // SCK fall that precedes the first data bit.
                r_read     <= 1'b1;
                r_capture  <= 1'b1;
                r_inc_pend <= 1'b1;
                r_state    <= S_RDATA;
              end else begin
                r_state    <= S_WDATA;
              end
            end
          end

          S_WDATA: begin
            if (w_byte_done) begin
              r_datao    <= w_byte_in;
              r_write    <= 1'b1;
              r_inc_pend <= 1'b1;
              r_len      <= r_len - 8'd1;
              if (r_len == 8'd1) r_state <= S_OVER;
            end
          end

          S_RDATA: begin
            if (w_byte_done) begin
              r_len <= r_len - 8'd1;
              if (r_len == 8'd1) begin
                r_state <= S_OVER;
                r_miso  <= 1'b0;
              end else begin
                // Prefetch the next byte during the last bit of this one.
                r_read     <= 1'b1;
                r_capture  <= 1'b1;
                r_inc_pend <= 1'b1;
              end
            end else if (w_sck_fall) begin
              // The fall following a byte boundary (bit counter wrapped to 0)
              // loads the prefetched byte; every other fall shifts MSB first.
              if (r_bit_cnt == 3'd0) begin
                r_shift_out <= r_hold;
                r_miso      <= r_hold[7];
              end else begin
                r_shift_out <= {r_shift_out[6:0], 1'b0};
                r_miso      <= r_shift_out[6];
              end
            end
          end

          S_OVER: begin
            r_miso <= 1'b0;
            if (w_sck_rise && !r_overrun) begin
              r_frame_error <= 1'b1;
              r_overrun     <= 1'b1;
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign spi_miso      = r_miso;
  assign spi_miso_oe   = r_miso_oe;
  assign reg_address   = r_address;
  assign reg_bytecnt   = r_bytecnt;
  assign reg_datao     = r_datao;
  assign reg_read      = r_read;
  assign reg_write     = r_write;
  assign reg_addrvalid = r_addrvalid;
  assign busy          = (r_state != S_IDLE);
  assign frame_error   = r_frame_error;

endmodule

// File: tb/tb_sam_spi_reg_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sam_spi_reg_responder
//
// Directed bench for sam_spi_reg_responder: an SPI mode-0 master drives frames
// at 16 clk_usb cycles per SCK period, a small register-bus model answers
// reads, and a negedge monitor logs every strobe for later comparison.
// -----------------------------------------------------------------------------
module tb_sam_spi_reg_responder;

  localparam int HALF = 80;   // half SCK period: 8 clk_usb cycles
  localparam int TCLK = 10;

  logic       clk_usb = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable  = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] reg_address;
  logic [6:0] reg_bytecnt;
  logic [7:0] reg_datao;
  logic [7:0] reg_datai;
  logic       reg_read, reg_write, reg_addrvalid, busy, frame_error;

  always #5 clk_usb = ~clk_usb;

  sam_spi_reg_responder #(.pBYTECNT_SIZE(7)) dut (
    .clk_usb       (clk_usb),
    .reset_n       (reset_n),
    .enable        (enable),
    .spi_sck       (spi_sck),
    .spi_mosi      (spi_mosi),
    .spi_cs_n      (spi_cs_n),
    .spi_miso      (spi_miso),
    .spi_miso_oe   (spi_miso_oe),
    .reg_address   (reg_address),
    .reg_bytecnt   (reg_bytecnt),
    .reg_datao     (reg_datao),
    .reg_datai     (reg_datai),
    .reg_read      (reg_read),
    .reg_write     (reg_write),
    .reg_addrvalid (reg_addrvalid),
    .busy          (busy),
    .frame_error   (frame_error)
  );

  // Register-bus read data as a function of the byte index.
  function automatic logic [7:0] bus_model(input logic [6:0] bc);
    case (bc)
      7'd0:    return 8'hA5;
      7'd1:    return 8'h3C;
      default: return {1'b1, bc} ^ 8'h33;
    endcase
  endfunction

  always_comb reg_datai = bus_model(reg_bytecnt);

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Strobe monitor (sampled on the falling clk edge, between DUT updates)
  // ---------------------------------------------------------------------------
  int         n_wr   = 0;
  int         n_rd   = 0;
  int         n_fe   = 0;
  int         n_both = 0;
  logic [7:0] wr_addr [512];
  logic [6:0] wr_bc   [512];
  logic [7:0] wr_data [512];
  logic [6:0] rd_bc   [512];

  always @(negedge clk_usb) begin
    if (reg_write) begin
      wr_addr[n_wr[8:0]] <= reg_address;
      wr_bc[n_wr[8:0]]   <= reg_bytecnt;
      wr_data[n_wr[8:0]] <= reg_datao;
      n_wr <= n_wr + 1;
    end
    if (reg_read) begin
      rd_bc[n_rd[8:0]] <= reg_bytecnt;
      n_rd <= n_rd + 1;
    end
    if (frame_error) n_fe <= n_fe + 1;
    if (reg_read && reg_write) n_both <= n_both + 1;
  end

  // ---------------------------------------------------------------------------
  // SPI master (mode 0, MSB first; MISO sampled just before each rise)
  // ---------------------------------------------------------------------------
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = tx[i];
      #HALF;
      rx[i]   = spi_miso;
      spi_sck = 1'b1;
      #HALF;
      spi_sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx);
    logic [7:0] rx;
    spi_bits(tx, 8, rx);
  endtask

  task automatic frame_start();
    @(negedge clk_usb);
    spi_cs_n = 1'b0;
    #(6*TCLK);
  endtask

  task automatic frame_end();
    #HALF;
    spi_cs_n = 1'b1;
    #(20*TCLK);
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    int         wb, rb, fb, idx;
    logic [7:0] rx0, rx1, rxk;

    // Reset state
    #(5*TCLK);
    @(negedge clk_usb);
    reset_n = 1'b1;
    #(10*TCLK);
    check("rst_address",   32'(reg_address), 0);
    check("rst_bytecnt",   32'(reg_bytecnt), 0);
    check("rst_datao",     32'(reg_datao), 0);
    check("rst_strobes",   {30'd0, reg_read, reg_write}, 0);
    check("rst_addrvalid", 32'(reg_addrvalid), 0);
    check("rst_busy",      32'(busy), 0);
    check("rst_miso",      {30'd0, spi_miso, spi_miso_oe}, 0);
    check("rst_ferr",      32'(n_fe), 0);

    // Write burst: addr 0x1A, cmd 0x03, data 11 22 33
    wb = n_wr; fb = n_fe;
    frame_start();
    spi_byte(8'h1A);
    spi_byte(8'h03);
    check("wr_addrvalid", 32'(reg_addrvalid), 1);
    check("wr_busy",      32'(busy), 1);
    check("wr_oe",        32'(spi_miso_oe), 1);
    spi_byte(8'h11);
    spi_byte(8'h22);
    spi_byte(8'h33);
    frame_end();
    check("wr_count", 32'(n_wr - wb), 3);
    for (int k = 0; k < 3; k++) begin
      idx = wb + k;
      check($sformatf("wr_addr%0d", k), 32'(wr_addr[idx[8:0]]), 32'h1A);
      check($sformatf("wr_bc%0d", k),   32'(wr_bc[idx[8:0]]), 32'(k));
      check($sformatf("wr_data%0d", k), 32'(wr_data[idx[8:0]]), 32'(8'h11 * (k + 1)));
    end
    check("wr_ferr",        32'(n_fe - fb), 0);
    check("wr_addrvalid_0", 32'(reg_addrvalid), 0);
    check("wr_sticky_addr", 32'(reg_address), 32'h1A);
    check("wr_sticky_bc",   32'(reg_bytecnt), 3);
    check("wr_oe_after",    32'(spi_miso_oe), 0);

    // Read burst: addr 0x05, cmd 0x82
    rb = n_rd; fb = n_fe;
    frame_start();
    spi_byte(8'h05);
    spi_byte(8'h82);
    spi_bits(8'h00, 8, rx0);
    spi_bits(8'h00, 8, rx1);
    check("rd_oe_during", 32'(spi_miso_oe), 1);
    frame_end();
    check("rd_byte0", 32'(rx0), 32'hA5);
    check("rd_byte1", 32'(rx1), 32'h3C);
    check("rd_count", 32'(n_rd - rb), 2);
    idx = rb;
    check("rd_bc0", 32'(rd_bc[idx[8:0]]), 0);
    idx = rb + 1;
    check("rd_bc1", 32'(rd_bc[idx[8:0]]), 1);
    check("rd_addr", 32'(reg_address), 32'h05);
    check("rd_ferr", 32'(n_fe - fb), 0);
    check("rd_oe_after", 32'(spi_miso_oe), 0);

    // Abort: cmd 0x02, CS raised after 4 bits of the second data byte
    wb = n_wr; fb = n_fe;
    frame_start();
    spi_byte(8'h21);
    spi_byte(8'h02);
    spi_byte(8'hC3);
    spi_bits(8'hF0, 4, rxk);
    frame_end();
    check("ab_count", 32'(n_wr - wb), 1);
    idx = wb;
    check("ab_data",  32'(wr_data[idx[8:0]]), 32'hC3);
    check("ab_ferr",  32'(n_fe - fb), 1);
    check("ab_busy",  32'(busy), 0);

    // Overrun: cmd 0x01 followed by two data bytes
    wb = n_wr; rb = n_rd; fb = n_fe;
    frame_start();
    spi_byte(8'h30);
    spi_byte(8'h01);
    spi_byte(8'h9D);
    spi_byte(8'h6E);
    check("ov_ferr_during", 32'(n_fe - fb), 1);
    frame_end();
    check("ov_count", 32'(n_wr - wb), 1);
    idx = wb;
    check("ov_data",  32'(wr_data[idx[8:0]]), 32'h9D);
    check("ov_ferr",  32'(n_fe - fb), 1);
    check("ov_reads", 32'(n_rd - rb), 0);

    // Length 0: cmd 0x80 -> 128 reads
    rb = n_rd; fb = n_fe;
    frame_start();
    spi_byte(8'h07);
    spi_byte(8'h80);
    for (int k = 0; k < 128; k++) begin
      spi_bits(8'h00, 8, rxk);
      check($sformatf("l0_rx%0d", k), 32'(rxk), 32'(bus_model(7'(k))));
    end
    frame_end();
    check("l0_count", 32'(n_rd - rb), 128);
    for (int k = 0; k < 128; k++) begin
      idx = rb + k;
      check($sformatf("l0_bc%0d", k), 32'(rd_bc[idx[8:0]]), 32'(k));
    end
    check("l0_ferr", 32'(n_fe - fb), 0);

    // Reset pulsed mid-read
    fb = n_fe;
    frame_start();
    spi_byte(8'h05);
    spi_byte(8'h82);
    spi_bits(8'h00, 8, rxk);
    spi_bits(8'h00, 3, rxk);
    #(3*TCLK + 1);
    reset_n = 1'b0;
    #1;
    check("mr_address",   32'(reg_address), 0);
    check("mr_bytecnt",   32'(reg_bytecnt), 0);
    check("mr_addrvalid", 32'(reg_addrvalid), 0);
    check("mr_busy",      32'(busy), 0);
    check("mr_miso",      {30'd0, spi_miso, spi_miso_oe}, 0);
    #(3*TCLK);
    @(negedge clk_usb);
    reset_n = 1'b1;
    #(10*TCLK);
    check("mr_busy_after", 32'(busy), 0);
    spi_cs_n = 1'b1;
    #(20*TCLK);
    check("mr_ferr", 32'(n_fe - fb), 0);
    wb = n_wr;
    frame_start();
    spi_byte(8'h40);
    spi_byte(8'h01);
    spi_byte(8'h5E);
    frame_end();
    check("mr_next_count", 32'(n_wr - wb), 1);
    idx = wb;
    check("mr_next_addr", 32'(wr_addr[idx[8:0]]), 32'h40);
    check("mr_next_data", 32'(wr_data[idx[8:0]]), 32'h5E);
    check("mr_next_bc",   32'(wr_bc[idx[8:0]]), 0);

    // enable = 0 for a full frame
    wb = n_wr; rb = n_rd; fb = n_fe;
    enable = 1'b0;
    frame_start();
    spi_byte(8'h1A);
    spi_byte(8'h81);
    check("dis_oe",   32'(spi_miso_oe), 0);
    check("dis_busy", 32'(busy), 0);
    spi_byte(8'h77);
    frame_end();
    check("dis_writes", 32'(n_wr - wb), 0);
    check("dis_reads",  32'(n_rd - rb), 0);
    check("dis_ferr",   32'(n_fe - fb), 0);
    enable = 1'b1;
    #(10*TCLK);

    check("no_rd_wr_overlap", 32'(n_both), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
